audio_in_meter: RTL and testbench

Capture side of the audio CODEC path. Drains stereo ADC samples from the codec read interface with the read_ready/read handshake and mixes each pair to a signed mono sample. Buffers mono samples in a 4-entry FIFO for downstream consumers and reports the peak absolute amplitude once per sample window, plus a loudness flag against a threshold. Sits beside the playback path, clocked from CLOCK_50 and sharing the codec's reset.

---
 rtl/audio_in_meter.sv | 157 +++++++++++++++
 tb/tb_audio_in_meter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_in_meter.sv
// audio_in_meter
// Capture side of the codec path. Acknowledges stereo ADC pairs from the codec
// read interface, mixes each pair to a signed mono sample, buffers the mono
// samples in a 4-entry FIFO and meters the peak absolute amplitude per window.
//
// Ports:
//   CLOCK_50        system clock, all logic on the rising edge
//   reset           synchronous, active-high
//   read_ready      codec has a stereo pair available
//   readdata_left   signed 24-bit left sample, valid while read_ready=1
//   readdata_right  signed 24-bit right sample, valid while read_ready=1
//   read            one-cycle acknowledge, codec advances to the next pair
//   out_data        signed mono sample at the FIFO head
//   out_valid       FIFO non-empty
//   out_ready       consumer pop request
//   level           peak |mono| of the last completed window
//   level_valid     one-cycle pulse when level updates
//   loud            level >= THRESH (sticky when peak hold is enabled)
//   dbg_state       current FSM state (IDLE=0, ACK=1, PROC=2)
//
// Handshakes: a codec pair is consumed only in the cycle read=1 (read is the
// acknowledge for read_ready); a FIFO entry is consumed only in a cycle where
// out_valid=1 and out_ready=1, and out_data is held stable until then.
//
// Build option: define AUDIO_IN_METER_PEAK_HOLD_EN to make loud sticky until
// reset; without it loud follows each new level.
module audio_in_meter #(
  parameter int unsigned WINDOW = 4800,
  parameter logic [23:0] THRESH = 24'h200000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        read_ready,
  input  logic [23:0] readdata_left,
  input  logic [23:0] readdata_right,
  output logic        read,
  output logic [23:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] level,
  output logic        level_valid,
  output logic        loud,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    PROC = 2'd2
  } state_t;

  localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);

  state_t state, state_next;

  logic [23:0] left_q, right_q;
  logic [23:0] mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic [23:0] peak;
  logic [15:0] win_cnt;

  logic signed [24:0] sum;
  logic [23:0] mono, mag, peak_max;
  logic        push, pop;

  // FSM state register
  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next state: a pair is only taken when the FIFO has room, so the
  // push in PROC can never overflow.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (read_ready && (count < 3'd4)) state_next = ACK;
      ACK:     state_next = PROC;
      PROC:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Gated with reset so the codec is never acknowledged while reset is held.
  assign read      = (state == ACK) && !reset;
  assign dbg_state = state;

  always_ff @(posedge CLOCK_50) begin
    if (state == ACK) begin
      left_q  <= readdata_left;
      right_q <= readdata_right;
    end
  end

  // 25-bit sum then halve: the result always fits in 24 bits.
  assign sum  = $signed({left_q[23], left_q}) + $signed({right_q[23], right_q});
  assign mono = 24'(sum >>> 1);

  // -(-2^23) is not representable; clamp it to the largest positive value.
  assign mag = mono[23] ? ((mono == 24'h800000) ? 24'h7FFFFF : (~mono + 24'd1))
                        : mono;
  assign peak_max = (mag > peak) ? mag : peak;

  assign push = (state == PROC);
  assign pop  = out_valid && out_ready;

  // 4-entry FIFO, pointers wrap naturally at 2 bits.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
      for (int i = 0; i < 4; i++) mem[i] <= 24'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= mono;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, push} - {2'b00, pop};
    end
  end

  assign out_valid = (count != 3'd0);
  assign out_data  = mem[rd_ptr];

  // Window meter
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      peak        <= 24'd0;
      win_cnt     <= 16'd0;
      level       <= 24'd0;
      level_valid <= 1'b0;
      loud        <= 1'b0;
    end else begin
      level_valid <= 1'b0;
      if (state == PROC) begin
        if (win_cnt == WIN_LAST) begin
          level       <= peak_max;
          peak        <= 24'd0;
          win_cnt     <= 16'd0;
          level_valid <= 1'b1;
`ifdef AUDIO_IN_METER_PEAK_HOLD_EN
          loud        <= loud | (peak_max >= THRESH);
`else
          loud        <= (peak_max >= THRESH);
`endif
        end else begin
          peak    <= peak_max;
          win_cnt <= win_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_in_meter.sv
// Testbench for audio_in_meter with WINDOW=4, THRESH=24'h400000.
// A codec model feeds pairs from queues; a reference model computes mono,
// magnitude and per-window peaks with plain integer arithmetic.
module tb_audio_in_meter;

  localparam int          WINDOW = 4;
  localparam logic [23:0] THRESH = 24'h400000;

  logic        clk = 1'b0;
  logic        reset;
  logic        read_ready;
  logic [23:0] readdata_left, readdata_right;
  logic        read;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] level;
  logic        level_valid;
  logic        loud;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  audio_in_meter #(.WINDOW(WINDOW), .THRESH(THRESH)) dut (
    .CLOCK_50      (clk),
    .reset         (reset),
    .read_ready    (read_ready),
    .readdata_left (readdata_left),
    .readdata_right(readdata_right),
    .read          (read),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .level         (level),
    .level_valid   (level_valid),
    .loud          (loud),
    .dbg_state     (dbg_state)
  );

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [23:0] exp;
  } mix_vec_t;

  mix_vec_t    vecs [8];
  logic [23:0] codec_l [$];
  logic [23:0] codec_r [$];
  logic [23:0] exp_q   [$];
  logic [23:0] win_q   [$];
  logic [23:0] lvl_q   [$];

  int n_tests = 0;
  int n_fail  = 0;
  int rd_pulses = 0;
  int lv_pulses = 0;
  int n_pops = 0;
  bit prev_read = 1'b0;
  bit last_read = 1'b0;
  bit sticky = 1'b0;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] mix(input logic [23:0] l, input logic [23:0] r);
    int s;
    s = int'($signed(l)) + int'($signed(r));
    return 24'(s >>> 1);
  endfunction

  function automatic logic [23:0] mag(input logic [23:0] m);
    int v;
    v = int'($signed(m));
    if (v < 0) v = -v;
    if (v > 'h7FFFFF) v = 'h7FFFFF;
    return 24'(v);
  endfunction

  function automatic logic [23:0] rand24();
    case ($urandom_range(0, 7))
      0:       return 24'h800000;
      1:       return 24'h7FFFFF;
      2:       return 24'h000000;
      default: return 24'($urandom);
    endcase
  endfunction

  task automatic drive_codec();
    read_ready     = (codec_l.size() > 0);
    readdata_left  = (codec_l.size() > 0) ? codec_l[0] : 24'd0;
    readdata_right = (codec_r.size() > 0) ? codec_r[0] : 24'd0;
  endtask

  task automatic add_pair(input logic [23:0] l, input logic [23:0] r);
    codec_l.push_back(l);
    codec_r.push_back(r);
    drive_codec();
  endtask

  // One clock: observe at negedge, update the codec just after the rising edge.
  task automatic tick();
    bit ack;
    logic [23:0] m, mx, e;
    bit le;
    ack = 1'b0;
    @(negedge clk);
    if (reset) begin
      check(!read, "read_in_reset", read, 0);
      exp_q.delete();
      win_q.delete();
      lvl_q.delete();
      sticky    = 1'b0;
      prev_read = 1'b0;
    end else begin
      if (read) begin
        rd_pulses++;
        ack = 1'b1;
        check(!prev_read, "read_back_to_back", 1, 0);
        check(exp_q.size() < 4, "read_when_full", exp_q.size(), 3);
        if (codec_l.size() == 0) begin
          check(1'b0, "read_no_data", 1, 0);
        end else begin
          m = mix(codec_l[0], codec_r[0]);
          exp_q.push_back(m);
          win_q.push_back(mag(m));
          if (win_q.size() == WINDOW) begin
            mx = 24'd0;
            foreach (win_q[i]) if (win_q[i] > mx) mx = win_q[i];
            lvl_q.push_back(mx);
            win_q.delete();
          end
        end
      end
      if (level_valid) begin
        lv_pulses++;
        if (lvl_q.size() == 0) begin
          check(1'b0, "level_valid_unexpected", 1, 0);
        end else begin
          e = lvl_q.pop_front();
          check(level == e, "level", level, e);
          sticky = sticky | (e >= THRESH);
`ifdef AUDIO_IN_METER_PEAK_HOLD_EN
          le = sticky;
`else
          le = (e >= THRESH);
`endif
          check(loud == le, "loud", loud, le);
        end
      end
      if (out_valid && out_ready) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          check(1'b0, "pop_empty_model", out_data, 0);
        end else begin
          e = exp_q.pop_front();
          check(out_data == e, "fifo_data", out_data, e);
        end
      end
      prev_read = read;
    end
    @(posedge clk);
    #1;
    if (ack) begin
      void'(codec_l.pop_front());
      void'(codec_r.pop_front());
    end
    last_read = ack;
    drive_codec();
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    out_ready = 1'b1;
    while ((codec_l.size() > 0 || exp_q.size() > 0) && k < budget) begin
      tick();
      k++;
    end
    check(k < budget, "drain_timeout", k, budget);
    tick();
    out_ready = 1'b0;
  endtask

  task automatic wait_proc(input int budget);
    int k;
    k = 0;
    tick();
    while (!last_read && k < budget) begin
      tick();
      k++;
    end
    check(last_read, "wait_proc_timeout", k, budget);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lv0, rd0, np0;

    vecs[0] = '{24'h000100, 24'h000300, 24'h000200};
    vecs[1] = '{24'hFFFFFE, 24'hFFFFFC, 24'hFFFFFD};
    vecs[2] = '{24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF};
    vecs[3] = '{24'h800000, 24'h800000, 24'h800000};
    vecs[4] = '{24'h000001, 24'h000000, 24'h000000};
    vecs[5] = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF};
    vecs[6] = '{24'h7FFFFF, 24'h800000, 24'hFFFFFF};
    vecs[7] = '{24'h000003, 24'h000002, 24'h000002};

    reset = 1'b1;
    out_ready = 1'b0;
    read_ready = 1'b0;
    readdata_left = 24'd0;
    readdata_right = 24'd0;

    // Reset held with a pair waiting
    add_pair(vecs[0].l, vecs[0].r);
    @(posedge clk);
    #1;
    repeat (3) tick();
    check(read == 1'b0, "rst_read", read, 0);
    check(out_data == 24'd0, "rst_out_data", out_data, 0);
    check(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
    check(level == 24'd0, "rst_level", level, 0);
    check(level_valid == 1'b0, "rst_level_valid", level_valid, 0);
    check(loud == 1'b0, "rst_loud", loud, 0);
    reset = 1'b0;

    // Mono mix table; vector 0 is already waiting at the codec
    for (int i = 0; i < 8; i++) begin
      if (i > 0) add_pair(vecs[i].l, vecs[i].r);
      tick();
      check(read == 1'b1, "mix_read_cycle1", read, 1);
      tick();
      tick();
      check(out_valid == 1'b1, "mix_latency", out_valid, 1);
      check(out_data == vecs[i].exp, "mix_data", out_data, vecs[i].exp);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();
    end

    // Backpressure: 4 reads fill the FIFO, one pop allows exactly one more
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) add_pair(rand24(), rand24());
    rd0 = rd_pulses;
    repeat (30) tick();
    check(rd_pulses - rd0 == 4, "bp_reads_full", rd_pulses - rd0, 4);
    check(out_valid == 1'b1, "bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    repeat (20) tick();
    check(rd_pulses - rd0 == 5, "bp_reads_after_pop", rd_pulses - rd0, 5);
    drain(200);

    // Saturation and meter
    reset_pulse();
    lv0 = lv_pulses;
    add_pair(24'h000010, 24'h000010);
    add_pair(24'h800000, 24'h800000);
    add_pair(24'h000020, 24'h000020);
    add_pair(24'h7FFFFF, 24'h7FFFFF);
    drain(100);
    check(lv_pulses - lv0 == 1, "meter_pulses_w1", lv_pulses - lv0, 1);
    check(level == 24'h7FFFFF, "meter_level_w1", level, 24'h7FFFFF);
    check(loud == 1'b1, "meter_loud_w1", loud, 1);
    for (int i = 0; i < 4; i++) add_pair(24'h0, 24'h0);
    drain(100);
    check(lv_pulses - lv0 == 2, "meter_pulses_w2", lv_pulses - lv0, 2);
    check(level == 24'h000000, "meter_level_w2", level, 0);
`ifdef AUDIO_IN_METER_PEAK_HOLD_EN
    check(loud == 1'b1, "meter_loud_w2", loud, 1);
`else
    check(loud == 1'b0, "meter_loud_w2", loud, 0);
`endif

    // Concurrent push/pop at 3 entries
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) add_pair(rand24(), rand24());
    repeat (15) tick();
    check(exp_q.size() == 3, "cc_fill3", exp_q.size(), 3);
    add_pair(rand24(), rand24());
    wait_proc(10);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    repeat (5) tick();
    np0 = n_pops;
    drain(100);
    check(n_pops - np0 == 3, "cc_remaining", n_pops - np0, 3);
    check(out_valid == 1'b0, "cc_empty", out_valid, 0);

    // Mid-operation reset in PROC
    reset_pulse();
    add_pair(rand24(), rand24());
    add_pair(rand24(), rand24());
    drain(100);
    lv0 = lv_pulses;
    add_pair(24'h123456, 24'h000000);
    wait_proc(10);
    reset_pulse();
    repeat (3) tick();
    check(out_valid == 1'b0, "mid_rst_no_push", out_valid, 0);
    for (int i = 0; i < WINDOW - 1; i++) add_pair(rand24(), rand24());
    drain(100);
    check(lv_pulses == lv0, "mid_rst_window_restart", lv_pulses - lv0, 0);
    add_pair(rand24(), rand24());
    drain(100);
    check(lv_pulses == lv0 + 1, "mid_rst_full_window", lv_pulses - lv0, 1);

    // Randomized traffic with random consumer stalls
    for (int i = 0; i < 300; i++) add_pair(rand24(), rand24());
    for (int k = 0; k < 5000 && codec_l.size() > 0; k++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    check(codec_l.size() == 0, "rand_codec_drained", codec_l.size(), 0);
    drain(200);
    check(lvl_q.size() == 0, "rand_level_pending", lvl_q.size(), 0);
    check(out_valid == 1'b0, "rand_fifo_empty", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
